// File: rtl/bcp_scheduler.sv
// BCP_CORE sequencer: walks a clause range, round-robins clauses to evaluator lanes, collects verdicts.
// Optional BCP_SCHED_STATS_EN adds saturating stat_issued / stat_implied counters.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 15
`endif

module bcp_scheduler #(
    parameter int NUM_EVAL    = 2,
    parameter int CLAUSE_ID_W = 16,
    parameter int VAR_W       = `MAX_VARS_BITS + 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic [CLAUSE_ID_W-1:0]          start_clause_id,
    input  logic [CLAUSE_ID_W-1:0]          end_clause_id,
    input  logic                            abort,
    output logic                            bcp_busy,
    output logic                            done,
    output logic                            conflict,
    output logic [CLAUSE_ID_W-1:0]          conflict_clause_id,
    output logic [NUM_EVAL-1:0]             eval_start,
    output logic [CLAUSE_ID_W-1:0]          eval_clause_id,
    input  logic [NUM_EVAL-1:0]             eval_busy,
    input  logic [NUM_EVAL-1:0]             res_valid,
    input  logic [2*NUM_EVAL-1:0]           res_type,
    input  logic [NUM_EVAL*VAR_W-1:0]       res_var,
    input  logic [NUM_EVAL-1:0]             res_val,
    input  logic [NUM_EVAL*CLAUSE_ID_W-1:0] res_clause_id,
    output logic [NUM_EVAL-1:0]             res_ack,
    output logic                            imply_push,
    output logic [VAR_W-1:0]                imply_var,
    output logic                            imply_val,
    input  logic                            imply_full
`ifdef BCP_SCHED_STATS_EN
    ,
    output logic [31:0]                     stat_issued,
    output logic [31:0]                     stat_implied
`endif
);

    localparam int RRW = (NUM_EVAL > 1) ? $clog2(NUM_EVAL) : 1;
    localparam int OCW = $clog2(NUM_EVAL) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state, state_nx;
    logic [CLAUSE_ID_W:0]   next_id, next_id_nx;
    logic [CLAUSE_ID_W-1:0] end_id;
    logic [RRW-1:0]         rr_issue, rr_res;
    logic [OCW-1:0]         outstanding;

    logic           iss_found, res_found;
    logic [RRW-1:0] iss_lane, res_lane;
    logic           issue_now, ack_now, push_now, conf_now;
    logic           collecting;
    logic [1:0]     sel_type;

    function automatic logic [RRW-1:0] wrap_add(input logic [RRW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_EVAL) s = s - NUM_EVAL;
        return RRW'(s);
    endfunction

    always_comb begin
        iss_found = 1'b0;
        iss_lane  = '0;
        res_found = 1'b0;
        res_lane  = '0;
        for (int k = 0; k < NUM_EVAL; k++) begin
            if (!iss_found && !eval_busy[wrap_add(rr_issue, k)]) begin
                iss_found = 1'b1;
                iss_lane  = wrap_add(rr_issue, k);
            end
            if (!res_found && res_valid[wrap_add(rr_res, k)]) begin
                res_found = 1'b1;
                res_lane  = wrap_add(rr_res, k);
            end
        end
    end

    assign collecting = (state == ISSUE) || (state == DRAIN);
    assign issue_now  = (state == ISSUE) && !abort && !conflict &&
                        (next_id <= {1'b0, end_id}) && iss_found;
    assign sel_type   = res_type[{res_lane, 1'b0} +: 2];
    assign next_id_nx = next_id + {{CLAUSE_ID_W{1'b0}}, issue_now};

    // Units wait on imply_full unless a conflict already makes them moot
    always_comb begin
        ack_now  = 1'b0;
        push_now = 1'b0;
        conf_now = 1'b0;
        if (collecting && res_found) begin
            case (sel_type)
                2'b01: begin
                    if (conflict) begin
                        ack_now = 1'b1;
                    end else if (!imply_full) begin
                        ack_now  = 1'b1;
                        push_now = 1'b1;
                    end
                end
                2'b10: begin
                    ack_now  = 1'b1;
                    conf_now = !conflict;
                end
                default: ack_now = 1'b1;
            endcase
        end
    end

    always_comb begin
        eval_start = '0;
        res_ack    = '0;
        if (issue_now) eval_start[iss_lane] = 1'b1;
        if (ack_now)   res_ack[res_lane]    = 1'b1;
    end

    assign eval_clause_id = issue_now ? next_id[CLAUSE_ID_W-1:0] : '0;
    assign imply_push     = push_now;
    assign imply_var      = push_now ? res_var[res_lane*VAR_W +: VAR_W] : '0;
    assign imply_val      = push_now & res_val[res_lane];
    assign bcp_busy       = (state != IDLE);
    assign done           = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = (start_clause_id > end_clause_id) ? DONE : ISSUE;
            end
            ISSUE: begin
                if (abort || conflict || (next_id_nx > {1'b0, end_id})) state_nx = DRAIN;
            end
            DRAIN: begin
                if (outstanding == '0) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            next_id            <= '0;
            end_id             <= '0;
            rr_issue           <= '0;
            rr_res             <= '0;
            outstanding        <= '0;
            conflict           <= 1'b0;
            conflict_clause_id <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                end_id             <= end_clause_id;
                next_id            <= {1'b0, start_clause_id};
                conflict           <= 1'b0;
                conflict_clause_id <= '0;
            end else begin
                next_id <= next_id_nx;
            end
            if (issue_now) rr_issue <= wrap_add(iss_lane, 1);
            if (ack_now)   rr_res   <= wrap_add(res_lane, 1);
            case ({issue_now, ack_now})
                2'b10:   outstanding <= outstanding + OCW'(1);
                2'b01:   outstanding <= outstanding - OCW'(1);
                default: outstanding <= outstanding;
            endcase
            // First conflict accepted owns the clause ID
            if (conf_now) begin
                conflict           <= 1'b1;
                conflict_clause_id <= res_clause_id[res_lane*CLAUSE_ID_W +: CLAUSE_ID_W];
            end
        end
    end

`ifdef BCP_SCHED_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_issued  <= '0;
            stat_implied <= '0;
        end else begin
            if (issue_now && stat_issued != '1)  stat_issued  <= stat_issued + 32'd1;
            if (push_now && stat_implied != '1)  stat_implied <= stat_implied + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bcp_scheduler.sv
// Bench for bcp_scheduler: emulated evaluator lanes, cycle model, directed and random passes.
module tb_bcp_scheduler;

    localparam int N  = 2;
    localparam int CW = 16;
    localparam int VW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] start_clause_id = '0;
    logic [CW-1:0] end_clause_id = '0;
    logic          abort = 1'b0;
    logic          bcp_busy, done, conflict;
    logic [CW-1:0] conflict_clause_id;
    logic [N-1:0]  eval_start;
    logic [CW-1:0] eval_clause_id;
    logic [N-1:0]  eval_busy = '0;
    logic [N-1:0]  res_valid = '0;
    logic [2*N-1:0] res_type = '0;
    logic [N*VW-1:0] res_var = '0;
    logic [N-1:0]  res_val = '0;
    logic [N*CW-1:0] res_clause_id = '0;
    logic [N-1:0]  res_ack;
    logic          imply_push;
    logic [VW-1:0] imply_var;
    logic          imply_val;
    logic          imply_full = 1'b0;
`ifdef BCP_SCHED_STATS_EN
    logic [31:0]   stat_issued, stat_implied;
`endif

    bcp_scheduler #(.NUM_EVAL(N), .CLAUSE_ID_W(CW), .VAR_W(VW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .start_clause_id(start_clause_id), .end_clause_id(end_clause_id),
        .abort(abort), .bcp_busy(bcp_busy), .done(done), .conflict(conflict),
        .conflict_clause_id(conflict_clause_id), .eval_start(eval_start),
        .eval_clause_id(eval_clause_id), .eval_busy(eval_busy),
        .res_valid(res_valid), .res_type(res_type), .res_var(res_var),
        .res_val(res_val), .res_clause_id(res_clause_id), .res_ack(res_ack),
        .imply_push(imply_push), .imply_var(imply_var), .imply_val(imply_val),
        .imply_full(imply_full)
`ifdef BCP_SCHED_STATS_EN
        , .stat_issued(stat_issued), .stat_implied(stat_implied)
`endif
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Verdict tables keyed by clause ID: type, implied var/val, latency
    int vtype[int];
    int vvar[int];
    int vval[int];
    int vlat[int];
    bit lat_rand = 1'b0;

    // Evaluator lanes
    bit l_busy[N];
    bit l_valid[N];
    int l_rem[N], l_cid[N], l_type[N], l_var[N], l_val[N];

    // Reference model
    int m_phase, m_next, m_end, m_rri, m_rrr, m_out, m_cid;
    bit m_conf;

    // Per-pass observations
    int cyc = 0;
    int pass_start = -1;
    int p_busy, p_done, p_push, p_push_cyc, p_withheld, p_pvar, p_pval;
    int p_ids[$], p_lanes[$], p_ack_lane[$], p_ack_cyc[$];

    task automatic lanes_clear();
        for (int j = 0; j < N; j++) begin
            l_busy[j] = 0; l_valid[j] = 0; l_rem[j] = 0; l_cid[j] = 0;
            l_type[j] = 0; l_var[j] = 0; l_val[j] = 0;
        end
    endtask

    task automatic drive_lanes();
        for (int j = 0; j < N; j++) begin
            eval_busy[j]           = l_busy[j];
            res_valid[j]           = l_valid[j];
            res_type[2*j +: 2]     = l_valid[j] ? l_type[j][1:0] : 2'b00;
            res_var[j*VW +: VW]    = l_var[j][VW-1:0];
            res_val[j]             = l_val[j][0];
            res_clause_id[j*CW +: CW] = l_cid[j][CW-1:0];
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_next = 0; m_end = 0; m_rri = 0; m_rrr = 0;
        m_out = 0; m_conf = 0; m_cid = 0;
    endtask

    initial begin : compare
        int il, rl, t, j, rel, lat, old_out;
        bit ack, push, cnf, old_conf;
        model_reset();
        lanes_clear();
        drive_lanes();
        forever begin
            @(negedge clock);
            cyc++;
            if (!reset) begin
                model_reset();
                lanes_clear();
                drive_lanes();
                chk("reset_outputs",
                    {bcp_busy, done, conflict, eval_start, res_ack, imply_push}, 0);
                continue;
            end
            il = -1;
            if (m_phase == 1 && !abort && !m_conf && m_next <= m_end)
                for (int k = 0; k < N; k++) begin
                    j = (m_rri + k) % N;
                    if (il < 0 && !l_busy[j]) il = j;
                end
            rl = -1;
            if (m_phase == 1 || m_phase == 2)
                for (int k = 0; k < N; k++) begin
                    j = (m_rrr + k) % N;
                    if (rl < 0 && l_valid[j]) rl = j;
                end
            ack = 0; push = 0; cnf = 0;
            t = (rl >= 0) ? l_type[rl] : 0;
            if (rl >= 0) begin
                if (t == 1) begin
                    if (m_conf) ack = 1;
                    else if (!imply_full) begin ack = 1; push = 1; end
                end else if (t == 2) begin
                    ack = 1; cnf = !m_conf;
                end else ack = 1;
            end

            chk("eval_start", eval_start, (il >= 0) ? (64'd1 << il) : 64'd0);
            if (il >= 0) chk("eval_clause_id", eval_clause_id, m_next);
            chk("res_ack", res_ack, ack ? (64'd1 << rl) : 64'd0);
            chk("imply_push", imply_push, push);
            if (push) begin
                chk("imply_var", imply_var, l_var[rl]);
                chk("imply_val", imply_val, l_val[rl]);
            end
            chk("bcp_busy", bcp_busy, m_phase != 0);
            chk("done", done, m_phase == 3);
            chk("conflict", conflict, m_conf);
            if (m_conf) chk("conflict_clause_id", conflict_clause_id, m_cid);

            if (pass_start >= 0) begin
                rel = cyc - pass_start;
                if (m_phase != 0) p_busy++;
                if (m_phase == 3 && p_done < 0) p_done = rel;
                if (il >= 0) begin p_ids.push_back(m_next); p_lanes.push_back(il); end
                if (push) begin
                    p_push++; p_push_cyc = rel; p_pvar = l_var[rl]; p_pval = l_val[rl];
                end
                if (rl >= 0 && !ack) p_withheld++;
                if (ack) begin p_ack_lane.push_back(rl); p_ack_cyc.push_back(rel); end
            end

            for (int k = 0; k < N; k++) begin
                if (ack && rl == k) begin
                    l_busy[k] = 0; l_valid[k] = 0;
                end else if (l_busy[k] && !l_valid[k]) begin
                    if (l_rem[k] <= 1) l_valid[k] = 1;
                    else l_rem[k]--;
                end
            end
            if (il >= 0) begin
                lat = vlat.exists(m_next) ? vlat[m_next] :
                      (lat_rand ? int'($urandom_range(2, 5)) : 2);
                l_busy[il] = 1; l_valid[il] = 0; l_rem[il] = lat - 1;
                l_cid[il]  = m_next;
                l_type[il] = vtype.exists(m_next) ? vtype[m_next] : 0;
                l_var[il]  = vvar.exists(m_next) ? vvar[m_next] : 0;
                l_val[il]  = vval.exists(m_next) ? vval[m_next] : 0;
            end

            case (m_phase)
                0: if (start) begin
                    m_end = end_clause_id; m_next = start_clause_id;
                    m_conf = 0; m_cid = 0;
                    m_phase = (start_clause_id > end_clause_id) ? 3 : 1;
                    pass_start = cyc;
                    p_busy = 0; p_done = -1; p_push = 0; p_push_cyc = -1;
                    p_withheld = 0; p_pvar = 0; p_pval = 0;
                    p_ids.delete(); p_lanes.delete();
                    p_ack_lane.delete(); p_ack_cyc.delete();
                end
                1, 2: begin
                    old_out = m_out; old_conf = m_conf;
                    if (il >= 0) begin m_next++; m_rri = (il + 1) % N; m_out++; end
                    if (ack) begin m_rrr = (rl + 1) % N; m_out--; end
                    if (cnf) begin m_conf = 1; m_cid = l_cid[rl]; end
                    if (m_phase == 1) begin
                        if (abort || old_conf || m_next > m_end) m_phase = 2;
                    end else if (old_out == 0) m_phase = 3;
                end
                default: m_phase = 0;
            endcase

            @(posedge clock);
            #1;
            drive_lanes();
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic begin_pass(input int s, input int e);
        start_clause_id = s[CW-1:0];
        end_clause_id   = e[CW-1:0];
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    bit aborted;

    task automatic wait_done(input bit rnd, input bit abort_en);
        bit ok;
        ok = 0;
        aborted = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (p_done >= 0) begin ok = 1; break; end
            if (rnd) begin
                imply_full = ($urandom_range(0, 3) == 0);
                abort = abort_en && ($urandom_range(0, 24) == 0);
                if (abort) aborted = 1;
                if ($urandom_range(0, 19) == 0) begin
                    start = 1'b1;
                    start_clause_id = CW'($urandom);
                    end_clause_id   = CW'($urandom);
                end else start = 1'b0;
            end
        end
        start = 0; abort = 0; imply_full = 0;
        chk("pass_completes", ok, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic clear_tables();
        vtype.delete(); vvar.delete(); vval.delete(); vlat.delete();
    endtask

    initial begin : driver
        int s, len, e;
        step();
        do_reset();

        // Range 5..8, all satisfied
        begin_pass(5, 8);
        wait_done(0, 0);
        chk("t1_issue_count", p_ids.size(), 4);
        for (int i = 0; i < 4 && i < p_ids.size(); i++) begin
            chk("t1_issue_id", p_ids[i], 5 + i);
            chk("t1_issue_lane", p_lanes[i], i % 2);
        end
        chk("t1_done_cycle", p_done, 9);
        chk("t1_no_push", p_push, 0);
        chk("t1_no_conflict", conflict, 0);

        // Empty range
        begin_pass(10, 9);
        wait_done(0, 0);
        chk("t2_done_cycle", p_done, 1);
        chk("t2_busy_cycles", p_busy, 1);
        chk("t2_no_issue", p_ids.size(), 0);

        // Unit held by imply_full for three cycles
        clear_tables();
        vtype[3] = 1; vvar[3] = 7; vval[3] = 1;
        imply_full = 1'b1;
        begin_pass(3, 3);
        repeat (5) step();
        imply_full = 1'b0;
        wait_done(0, 0);
        chk("t3_withheld", p_withheld, 3);
        chk("t3_push_count", p_push, 1);
        chk("t3_push_cycle", p_push_cyc, 6);
        chk("t3_push_var", p_pvar, 7);
        chk("t3_push_val", p_pval, 1);

        // Conflict at clause 4 in 0..15, every other clause a unit
        clear_tables();
        for (int i = 0; i < 16; i++) begin
            vtype[i] = 1; vvar[i] = i + 1; vval[i] = i & 1;
        end
        vtype[4] = 2;
        begin_pass(0, 15);
        wait_done(0, 0);
        chk("t4_conflict", conflict, 1);
        chk("t4_conflict_id", conflict_clause_id, 4);
        chk("t4_issue_count", p_ids.size(), 6);
        chk("t4_push_count", p_push, 4);
        repeat (5) step();
        chk("t4_sticky", conflict, 1);

        // Top of ID space, no wrap
        clear_tables();
        begin_pass(16'hFFFE, 16'hFFFF);
        chk("t4_clear_on_start", conflict, 0);
        wait_done(0, 0);
        chk("t6_issue_count", p_ids.size(), 2);
        if (p_ids.size() == 2) begin
            chk("t6_id0", p_ids[0], 16'hFFFE);
            chk("t6_id1", p_ids[1], 16'hFFFF);
        end

        // Dual conflict with rr_res left at lane 1
        do_reset();
        clear_tables();
        vlat[30] = 4;
        begin_pass(30, 31);
        wait_done(0, 0);
        vtype[20] = 2; vtype[21] = 2; vlat[20] = 3;
        begin_pass(20, 21);
        wait_done(0, 0);
        chk("t5_conflict_id", conflict_clause_id, 21);
        chk("t5_ack_count", p_ack_lane.size(), 2);
        if (p_ack_lane.size() == 2) begin
            chk("t5_first_lane", p_ack_lane[0], 1);
            chk("t5_second_lane", p_ack_lane[1], 0);
            chk("t5_first_cycle", p_ack_cyc[0], 4);
            chk("t5_consecutive", p_ack_cyc[1] - p_ack_cyc[0], 1);
        end

        // Reset in the middle of ISSUE, then a fresh pass
        clear_tables();
        begin_pass(0, 40);
        repeat (4) step();
        reset = 1'b0;
        #1;
        chk("t7_outputs_zero",
            {bcp_busy, done, conflict, eval_start, res_ack, imply_push}, 0);
        step();
        reset = 1'b1;
        step();
        begin_pass(5, 8);
        wait_done(0, 0);
        chk("t7_issue_count", p_ids.size(), 4);
        for (int i = 0; i < 4 && i < p_ids.size(); i++) begin
            chk("t7_issue_id", p_ids[i], 5 + i);
            chk("t7_issue_lane", p_lanes[i], i % 2);
        end

        // abort while idle is ignored
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();

        // Random passes
        lat_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            clear_tables();
            s   = $urandom_range(1, 300);
            len = $urandom_range(0, 20);
            e   = s + len - 1;
            for (int id = s; id <= e; id++) begin
                int r;
                r = $urandom_range(0, 99);
                vtype[id] = (r < 50) ? 0 : (r < 80) ? 1 : (r < 84) ? 2 : 3;
                vvar[id]  = $urandom_range(0, 65535);
                vval[id]  = $urandom_range(0, 1);
            end
            begin_pass(s, e);
            wait_done(1, (p % 3) == 0);
            for (int i = 0; i < p_ids.size(); i++)
                chk("rand_contiguous_id", p_ids[i], s + i);
            if (!aborted && !m_conf)
                chk("rand_issue_count", p_ids.size(), len);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
